// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg: sequencer state encoding and default network dimensions shared by the NN control blocks
package nn_ctrl_pkg;
    typedef enum logic [2:0] {
        LS_IDLE,
        LS_LAUNCH,
        LS_WAIT,
        LS_ADVANCE,
        LS_HOLD,
        LS_DONE,
        LS_ERROR
    } ls_state_e;
    localparam int NN_NUM_LAYERS = 3;
    localparam int NN_LAYER_W    = 2;
    localparam int NN_TIMEOUT_W  = 16;
endpackage

// File: rtl/layer_watchdog.sv
// layer_watchdog: saturating per-layer wait counter with an expiry compare (limit 0 never expires)
module layer_watchdog
    import nn_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = NN_TIMEOUT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [TIMEOUT_W-1:0] limit_i,
    output logic                 expired_o
);
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d, inc;
    // Expiry looks at the post-increment value so the limit counts WAIT cycles exactly
    assign inc       = &cnt_q ? cnt_q : cnt_q + 1'b1;
    assign cnt_d     = clr_i ? '0 : en_i ? inc : cnt_q;
    assign expired_o = en_i && (limit_i != '0) && (inc == limit_i);
    always_ff @(posedge clk) begin
        cnt_q <= reset ? '0 : cnt_d;
    end
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: walks the network layer by layer, launching the RAM/MAC controller under a per-layer watchdog
module layer_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int NUM_LAYERS = NN_NUM_LAYERS,
    parameter int LAYER_W    = NN_LAYER_W,
    parameter int TIMEOUT_W  = NN_TIMEOUT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 step_mode,
    input  logic                 step,
    input  logic                 continuous,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    input  logic                 layer_done,
    output logic                 ram_start,
    output logic [LAYER_W-1:0]   layer,
    output logic                 layer_sel,
    output logic                 busy,
    output logic                 net_done,
    output logic                 timeout_err
);
    localparam logic [LAYER_W-1:0] LAST = LAYER_W'(NUM_LAYERS - 1);
    ls_state_e          state_q, state_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic               err_q, err_d;
    logic               wd_expired;

    layer_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_wd (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q == LS_LAUNCH),
        .en_i      (state_q == LS_WAIT && !layer_done),
        .limit_i   (timeout_limit),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LS_IDLE;
            layer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        err_d   = err_q;
        if (abort) begin
            state_d = LS_IDLE;
            layer_d = '0;
        end else begin
            case (state_q)
                LS_IDLE: begin
                    layer_d = '0;
                    state_d = start ? LS_LAUNCH : LS_IDLE;
                end
                LS_LAUNCH: state_d = LS_WAIT;
                LS_WAIT: begin
                    state_d = layer_done ? LS_ADVANCE : wd_expired ? LS_ERROR : LS_WAIT;
                    err_d   = err_q || (!layer_done && wd_expired);
                end
                LS_ADVANCE: begin
                    layer_d = (layer_q == LAST) ? '0 : layer_q + 1'b1;
                    state_d = (layer_q == LAST) ? LS_DONE : step_mode ? LS_HOLD : LS_LAUNCH;
                end
                LS_HOLD: state_d = step ? LS_LAUNCH : LS_HOLD;
                LS_DONE: state_d = continuous ? LS_LAUNCH : LS_IDLE;
                LS_ERROR: if (start) begin
                    err_d   = 1'b0;
                    layer_d = '0;
                    state_d = LS_LAUNCH;
                end
                default: state_d = LS_IDLE;
            endcase
        end
    end

    always_comb begin
        ram_start   = state_q == LS_LAUNCH;
        net_done    = state_q == LS_DONE;
        busy        = !(state_q == LS_IDLE || state_q == LS_ERROR);
        timeout_err = err_q;
        layer       = layer_q;
        layer_sel   = layer_q != LAST;
    end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed scenarios plus random traffic on 3- and 5-layer sequencers against a behavioural model
module tb_layer_sequencer;
    localparam int P_IDLE = 0, P_LAUNCH = 1, P_WAIT = 2, P_ADV = 3, P_HOLD = 4, P_DONE = 5, P_ERR = 6;
    logic        clk = 1'b0;
    logic        reset, start, abort, step_mode, step, continuous, layer_done;
    logic [15:0] timeout_limit;
    logic [1:0]  rs, sel, bsy, nd, te;
    logic [1:0]  lay0;
    logic [2:0]  lay1;
    logic [1:0]  rs_s, sel_s, bsy_s, nd_s, te_s;
    int          lay_s[2];
    int          n_tests = 0, n_fail = 0;
    int          ph[2], ly[2], wt[2], nl[2];
    bit          er[2];
    int          cd, n, seq, selc, n_rs0, n_nd0, n_rs1, n_nd1, lat;
    bit          found;

    always #5 clk = ~clk;

    layer_sequencer u_dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .step_mode(step_mode), .step(step),
        .continuous(continuous), .timeout_limit(timeout_limit), .layer_done(layer_done),
        .ram_start(rs[0]), .layer(lay0), .layer_sel(sel[0]), .busy(bsy[0]), .net_done(nd[0]), .timeout_err(te[0])
    );

    layer_sequencer #(.NUM_LAYERS(5), .LAYER_W(3), .TIMEOUT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .step_mode(step_mode), .step(step),
        .continuous(continuous), .timeout_limit(timeout_limit), .layer_done(layer_done),
        .ram_start(rs[1]), .layer(lay1), .layer_sel(sel[1]), .busy(bsy[1]), .net_done(nd[1]), .timeout_err(te[1])
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step(input int k);
        if (reset) begin
            ph[k] = P_IDLE; ly[k] = 0; wt[k] = 0; er[k] = 0;
        end else if (abort) begin
            ph[k] = P_IDLE; ly[k] = 0;
        end else begin
            case (ph[k])
                P_IDLE:   if (start) ph[k] = P_LAUNCH;
                P_LAUNCH: begin wt[k] = 0; ph[k] = P_WAIT; end
                P_WAIT:
                    if (layer_done) ph[k] = P_ADV;
                    else begin
                        wt[k]++;
                        if (timeout_limit != 0 && wt[k] == int'(timeout_limit)) begin
                            ph[k] = P_ERR; er[k] = 1;
                        end
                    end
                P_ADV:
                    if (ly[k] == nl[k] - 1) begin ly[k] = 0; ph[k] = P_DONE; end
                    else begin ly[k]++; ph[k] = step_mode ? P_HOLD : P_LAUNCH; end
                P_HOLD:   if (step) ph[k] = P_LAUNCH;
                P_DONE:   ph[k] = continuous ? P_LAUNCH : P_IDLE;
                default:  if (start) begin er[k] = 0; ly[k] = 0; ph[k] = P_LAUNCH; end
            endcase
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        rs_s = rs; sel_s = sel; bsy_s = bsy; nd_s = nd; te_s = te;
        lay_s[0] = int'(lay0); lay_s[1] = int'(lay1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("i%0d.ram_start", k), int'(rs[k]), int'(ph[k] == P_LAUNCH));
            chk($sformatf("i%0d.busy", k), int'(bsy[k]), int'(ph[k] != P_IDLE && ph[k] != P_ERR));
            chk($sformatf("i%0d.net_done", k), int'(nd[k]), int'(ph[k] == P_DONE));
            chk($sformatf("i%0d.timeout_err", k), int'(te[k]), int'(er[k]));
            chk($sformatf("i%0d.layer", k), lay_s[k], ly[k]);
            chk($sformatf("i%0d.layer_sel", k), int'(sel[k]), int'(ly[k] != nl[k] - 1));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
    endtask

    task automatic rst_pass();
        {start, abort, step_mode, step, continuous, layer_done} = '0;
        timeout_limit = '0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        nl[0] = 3; nl[1] = 5;
        {start, abort, step_mode, step, continuous, layer_done} = '0;
        timeout_limit = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        reset = 1'b0;
        chk("rst.layer", int'(lay0), 0);
        chk("rst.layer_sel", int'(sel[0]), 1);
        chk("rst.busy", int'(bsy[0]), 0);
        chk("rst.ram_start", int'(rs[0]), 0);
        chk("rst.timeout_err", int'(te[1]), 0);

        // full pass, layer_done five cycles after every launch
        start = 1; cyc(); start = 0;
        cd = 0; seq = 0; selc = 0; n_rs0 = 0; n_nd0 = 0; n_rs1 = 0; n_nd1 = 0;
        for (int i = 0; i < 60; i++) begin
            layer_done = (cd == 1);
            if (cd > 0) cd--;
            cyc();
            if (rs_s[1]) cd = 5;
            if (rs_s[0]) begin
                n_rs0++; seq = seq * 4 + lay_s[0]; selc = selc * 2 + int'(sel_s[0]);
            end
            n_nd0 += int'(nd_s[0]); n_rs1 += int'(rs_s[1]); n_nd1 += int'(nd_s[1]);
        end
        layer_done = 0;
        chk("s1.rs_count0", n_rs0, 3);
        chk("s1.layer_seq0", seq, 6);
        chk("s1.sel_seq0", selc, 6);
        chk("s1.net_done0", n_nd0, 1);
        chk("s1.rs_count1", n_rs1, 5);
        chk("s1.net_done1", n_nd1, 1);
        chk("s1.idle_busy", int'(bsy_s), 0);

        // single-step hold after layer 0
        rst_pass();
        step_mode = 1; layer_done = 1; start = 1; cyc(); start = 0;
        repeat (3) cyc();
        layer_done = 0; n = 0;
        repeat (20) begin cyc(); n += int'(rs_s[0]) + int'(rs_s[1]); end
        chk("s2.hold_rs", n, 0);
        chk("s2.hold_layer0", lay_s[0], 1);
        chk("s2.hold_layer1", lay_s[1], 1);
        chk("s2.hold_busy", int'(bsy_s), 3);
        step = 1; cyc(); step = 0; cyc();
        chk("s2.step_rs", int'(rs_s), 3);
        step_mode = 0;

        // watchdog expiry on layer 1, then restart from ERROR
        rst_pass();
        timeout_limit = 4; layer_done = 1; start = 1; cyc(); start = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (rs_s[0] && lay_s[0] == 1) found = 1;
        end
        chk("s3.layer1_launch", int'(found), 1);
        layer_done = 0; lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            cyc();
            if (te_s[0]) lat = i;
        end
        chk("s3.err_latency", lat, 5);
        chk("s3.err_layer", lay_s[0], 1);
        chk("s3.err_busy", int'(bsy_s[0]), 0);
        start = 1; cyc(); start = 0; cyc();
        chk("s3.err_cleared", int'(te_s[0]), 0);
        chk("s3.restart_rs", int'(rs_s[0]), 1);
        chk("s3.restart_layer", lay_s[0], 0);
        timeout_limit = 0;

        // abort during WAIT of layer 1
        rst_pass();
        layer_done = 1; start = 1; cyc(); start = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (rs_s[0] && lay_s[0] == 1) found = 1;
        end
        layer_done = 0; cyc(); cyc();
        abort = 1; cyc(); abort = 0; cyc();
        chk("s4.abort_busy", int'(bsy_s), 0);
        chk("s4.abort_layer", lay_s[0], 0);
        chk("s4.abort_net_done", int'(nd_s), 0);
        layer_done = 1; n = 0;
        repeat (10) begin cyc(); n += int'(rs_s[0]) + int'(nd_s[0]); end
        chk("s4.late_done", n, 0);
        layer_done = 0;

        // continuous run with layer_done landing on the expiry cycle
        rst_pass();
        continuous = 1; timeout_limit = 3; start = 1; cyc(); start = 0;
        cd = 0; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            layer_done = (cd == 1);
            if (cd > 0) cd--;
            cyc();
            if (rs_s[1]) cd = 3;
            if (nd_s[1]) found = 1;
        end
        chk("s5.net_done_seen", int'(found), 1);
        layer_done = 0; cyc();
        chk("s5.relaunch_rs", int'(rs_s[1]), 1);
        chk("s5.relaunch_layer", lay_s[1], 0);
        chk("s5.no_timeout", int'(te_s), 0);
        continuous = 0; abort = 1; cyc(); abort = 0;

        // random traffic
        rst_pass();
        repeat (4000) begin
            start      = $urandom_range(0, 7) == 0;
            abort      = $urandom_range(0, 63) == 0;
            reset      = $urandom_range(0, 499) == 0;
            step       = $urandom_range(0, 3) == 0;
            layer_done = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 31) == 0) step_mode = ~step_mode;
            if ($urandom_range(0, 31) == 0) continuous = ~continuous;
            if ($urandom_range(0, 63) == 0) timeout_limit = 16'($urandom_range(0, 8));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
